// File: rtl/two_bit_adder.sv
// 2-bit ripple-carry adder built from two full-adder stages, plus a registered copy
// of {Cout,S} for pipelined users.

module two_bit_adder_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module two_bit_adder (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       Cin,
  output logic [1:0] S,
  output logic       Cout,
  output logic [1:0] S_q,
  output logic       Cout_q
);
  localparam int W = 2;

  // c[i] is the carry into bit i; c[W] is the carry out of the top stage
  logic [W:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    two_bit_adder_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .c  (c[i]),
      .s  (S[i]),
      .co (c[i+1])
    );
  end

  assign Cout = c[W];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      S_q    <= 2'b00;
      Cout_q <= 1'b0;
    end else begin
      S_q    <= S;
      Cout_q <= Cout;
    end
  end
endmodule

// File: tb/tb_two_bit_adder.sv
// Directed bench for two_bit_adder: exhaustive combinational sweep, carry and
// boundary vectors, and the registered copy across reset assert/release.

module tb_two_bit_adder;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] A, B;
  logic       Cin;
  logic [1:0] S, S_q;
  logic       Cout, Cout_q;

  int checks   = 0;
  int failures = 0;

  two_bit_adder dut (
    .clock   (clock),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
    .S       (S),
    .Cout    (Cout),
    .S_q     (S_q),
    .Cout_q  (Cout_q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] v;
    logic [2:0] e;

    // reset state of the registered copy
    reset_n = 1'b0; A = 2'd0; B = 2'd0; Cin = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    check("reset_regs", {Cout_q, S_q}, 3'b000);

    // exhaustive sweep: A[0] fastest, Cin slowest, 10 ns per vector
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      A = v[1:0]; B = v[3:2]; Cin = v[4];
      #1;
      e = 3'(v[1:0]) + 3'(v[3:2]) + 3'(v[4]);
      check($sformatf("sum_A%0d_B%0d_C%0d", v[1:0], v[3:2], v[4]), {Cout, S}, e);
      #9;
    end

    // boundaries
    A = 2'd3; B = 2'd3; Cin = 1'b1; #1;
    check("max_all_ones", {Cout, S}, 3'b111);
    A = 2'd0; B = 2'd0; Cin = 1'b0; #1;
    check("min_all_zero", {Cout, S}, 3'b000);

    // carry ripple
    A = 2'b01; B = 2'b01; Cin = 1'b1; #1;
    check("ripple_into_bit1", {Cout, S}, 3'b011);
    A = 2'b10; B = 2'b10; Cin = 1'b0; #1;
    check("carry_out_bit1", {Cout, S}, 3'b100);

    // registered path: still in reset so outputs held at 0
    @(posedge clock); #1;
    check("regs_held_in_reset", {Cout_q, S_q}, 3'b000);

    // release: first edge with reset_n high captures 2+3+1 = 6
    reset_n = 1'b1; A = 2'd2; B = 2'd3; Cin = 1'b1;
    #1;
    check("comb_2_3_1", {Cout, S}, 3'b110);
    @(posedge clock); #1;
    check("reg_capture_after_release", {Cout_q, S_q}, 3'b110);

    // new value registers with one-cycle latency: 1+1+0 = 2
    A = 2'd1; B = 2'd1; Cin = 1'b0; #1;
    check("reg_not_yet_updated", {Cout_q, S_q}, 3'b110);
    @(posedge clock); #1;
    check("reg_follow_1_1_0", {Cout_q, S_q}, 3'b010);

    // reset mid-run: registers clear, combinational path keeps tracking
    reset_n = 1'b0; A = 2'd3; B = 2'd2; Cin = 1'b0; #1;
    check("reg_before_reset_edge", {Cout_q, S_q}, 3'b010);
    @(posedge clock); #1;
    check("reg_cleared_mid_run", {Cout_q, S_q}, 3'b000);
    check("comb_during_reset", {Cout, S}, 3'b101);
    A = 2'd1; B = 2'd0; Cin = 1'b1; #1;
    check("comb_during_reset_2", {Cout, S}, 3'b010);
    @(posedge clock); #1;
    check("reg_stays_cleared", {Cout_q, S_q}, 3'b000);

    // release again
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("reg_capture_second_release", {Cout_q, S_q}, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
